// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the two-requester shift-add multiplier arbiter.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned STATS_W = 16;

    // Round-robin pick: on a tie the requester not granted last wins.
    function automatic logic [NUM_REQ-1:0] rr_grant(input logic [NUM_REQ-1:0] vld,
                                                    input logic               last);
        logic [NUM_REQ-1:0] gnt;
        gnt = '0;
        if (vld[0] && (!vld[1] || last)) begin
            gnt[0] = 1'b1;
        end else if (vld[1]) begin
            gnt[1] = 1'b1;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mul_step_core.sv
// Shift-add multiplier datapath: load clears the product, each step retires one multiplier bit.
module mul_step_core
    import mul_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           step,
    output logic [2*N-1:0] p
);

    localparam int unsigned PW = 2 * N;

    logic [PW-1:0] mcand;
    logic [N-1:0]  mplier;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            p      <= '0;
        end else if (load) begin
            mcand  <= PW'(a);
            mplier <= b;
            p      <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                p <= p + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mul_arb.sv
// Round-robin arbiter sharing one N-step shift-add multiplier between two requesters.
// Define MUL_ARB_STATS_EN to add per-requester completed-response counters.
module mul_arb
    import mul_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [N-1:0]        req0_a,
    input  logic [N-1:0]        req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [N-1:0]        req1_a,
    input  logic [N-1:0]        req1_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [2*N-1:0]      rsp_p,
    output logic                busy
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]  done0_cnt,
    output logic [STATS_W-1:0]  done1_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               last;
    logic [NUM_REQ-1:0] vld, gnt, rdy;
    logic               load, step, rsp_hs;
    logic [N-1:0]       op_a, op_b;

    assign vld        = {req1_valid, req0_valid};
    assign gnt        = rr_grant(vld, last);
    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];
    assign op_a       = gnt[1] ? req1_a : req0_a;
    assign op_b       = gnt[1] ? req1_b : req0_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state plus datapath sequencing; ready is only offered in IDLE and out of reset.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdy       = '0;
        load      = 1'b0;
        step      = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: begin
                rdy = gnt & {NUM_REQ{!rst}};
                if (|gnt) begin
                    load      = 1'b1;
                    cnt_nxt   = CNT_W'(N);
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step    = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pointer starts at 1 so requester 0 wins the first tie; it only moves on response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
            last      <= 1'b1;
        end else begin
            rsp_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
            if (load) begin
                rsp_id <= gnt[1];
            end
            if (rsp_hs) begin
                last <= rsp_id;
            end
        end
    end

    mul_step_core #(
        .N (N)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .a    (op_a),
        .b    (op_b),
        .step (step),
        .p    (rsp_p)
    );

`ifdef MUL_ARB_STATS_EN
    // Completed-response counters, wrapping naturally at 2^STATS_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done0_cnt <= '0;
            done1_cnt <= '0;
        end else if (rsp_hs) begin
            if (rsp_id) begin
                done1_cnt <= done1_cnt + STATS_W'(1);
            end else begin
                done0_cnt <= done0_cnt + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/mul_arb.md
MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have ports req0_valid (input, 1, requester 0 has operands) and req0_ready (output, 1, requester 0 operands accepted this cycle).
REQ-005 SHALL have ports req0_a and req0_b, input, N each, requester 0 operands.
REQ-006 SHALL have requester 1 ports req1_valid, req1_ready, req1_a and req1_b, with the same directions, widths and meanings as requester 0.
REQ-007 SHALL have ports rsp_valid (output, 1, result available) and rsp_ready (input, 1, consumer takes result).
REQ-008 SHALL have ports rsp_id (output, 1, index of the owning requester) and rsp_p (output, 2N, unsigned product).
REQ-009 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, RUN and DONE.
REQ-011 IDLE: SHALL grant at most one requester per cycle; reqX_ready SHALL be combinational, high only in IDLE for the granted requester.
REQ-012 Arbitration SHALL be round-robin:
- if both requesters are valid, grant the one not granted last;
- if one is valid, grant it.
REQ-013 On a handshake (valid and ready) at edge k:
- latch a, b and id;
- clear the product;
- load the cycle counter with N;
- enter RUN.
REQ-014 RUN: SHALL perform one shift-add step per cycle, N steps in total; enter DONE at edge k+N with rsp_valid=1 and the full 2N-bit product, no truncation.
REQ-015 DONE: rsp_valid, rsp_id and rsp_p SHALL stay stable until rsp_ready=1; on the rsp_ready edge, return to IDLE and update the last-grant pointer.
REQ-016 No new request SHALL be accepted in RUN or DONE; requester valids SHALL be ignored there, and reqX_ready SHALL be 0.
REQ-017 Minimum issue interval SHALL be N+2 cycles (accept, N steps, response edge).
REQ-018 Operand value 0 SHALL still take N RUN cycles and produce rsp_p=0.
REQ-019 A requester dropping valid before its handshake SHALL cause no action.

Reset
REQ-020 rst=1 SHALL asynchronously force:
- state IDLE;
- rsp_valid=0, rsp_p=0, rsp_id=0, busy=0;
- counter=0;
- last-grant pointer=1, so requester 0 wins the first tie.
REQ-021 Reset asserted in RUN or DONE SHALL discard the operation with no response issued.
REQ-022 With rst=1, reqX_ready SHALL be 0.

Configuration
REQ-023 Macro MUL_ARB_STATS_EN, when defined:
- adds outputs done0_cnt and done1_cnt, 16 bits each;
- each increments on a response handshake for its id;
- each wraps from 0xFFFF to 0;
- each resets to 0.
REQ-024 Without MUL_ARB_STATS_EN, these ports and their counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-025 A shared package mul_arb_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the requester-count constant (2);
- the stats counter width constant (16).
REQ-026 The shift-add datapath SHALL be a sub-module mul_step_core with ports clk, rst, load, a, b, step and p; mul_arb SHALL sequence it.

Verification (N=4)
REQ-027 Single request: req0 a=10, b=5, rsp_ready=1 -> rsp_valid exactly 4 cycles after the handshake; rsp_p=50, rsp_id=0.
REQ-028 Simultaneous request after reset: req0 a=3, b=2 and req1 a=15, b=14 -> first response 6/id 0, then 210/id 1; req1_ready=0 until the first response completes.
REQ-029 Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_p=4 for a=b=2 held stable, busy=1, both readys 0; released on rsp_ready.
REQ-030 Reset mid-RUN: assert rst 2 cycles after the handshake -> busy=0 and rsp_valid=0 immediately, no response; the next request completes normally.
REQ-031 Edge values: a=0, b=15 -> rsp_p=0 after 4 cycles; a=15, b=15 -> rsp_p=225.
REQ-032 Stats (MUL_ARB_STATS_EN): 3 req1 operations and 1 req0 operation -> done0_cnt=1, done1_cnt=3.
